// File: rtl/pixel_fetch_ctrl_pkg.sv
// Shared types and default geometry for the pixel fetch controller.
// Holds the FSM state encoding, the default frame/overlay sizes and the transparent key colour.
package pixel_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_BLANK  = 2'd3
    } state_e;

    localparam int          DEF_H_ACTIVE  = 640;
    localparam int          DEF_V_ACTIVE  = 480;
    localparam int          DEF_OVL_W     = 128;
    localparam int          DEF_OVL_H     = 128;
    localparam logic [23:0] DEF_KEY_COLOR = 24'hFF00FF;

    // Coordinates are one bit wider than the 10-bit overlay origin so differences never alias.
    localparam int COORD_W    = 11;
    localparam int BG_ADDR_W  = 19;
    localparam int OVL_ADDR_W = 14;

endpackage

// File: rtl/ovl_window_calc.sv
// Combinational overlay window test and overlay RAM address for one pixel position.
// Unsigned 11-bit differences make pixels left of / above the origin land far outside the window.
module ovl_window_calc
    import pixel_fetch_ctrl_pkg::*;
#(
    parameter int OVL_W = DEF_OVL_W,
    parameter int OVL_H = DEF_OVL_H
) (
    input  logic [COORD_W-1:0]    x_i,
    input  logic [COORD_W-1:0]    y_i,
    input  logic [9:0]            ox_i,
    input  logic [9:0]            oy_i,
    output logic                  in_win_o,
    output logic [OVL_ADDR_W-1:0] addr_o
);

    localparam int LOG2_W = $clog2(OVL_W);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;

    always_comb begin
        dx       = x_i - COORD_W'(ox_i);
        dy       = y_i - COORD_W'(oy_i);
        in_win_o = (dx < COORD_W'(OVL_W)) && (dy < COORD_W'(OVL_H));
        addr_o   = (OVL_ADDR_W'(dy) << LOG2_W) + OVL_ADDR_W'(dx);
    end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Scan-out fetch controller: walks the active frame, reads background and overlay RAMs,
// and composites the overlay over the background with a fixed two-cycle latency.
module pixel_fetch_ctrl
    import pixel_fetch_ctrl_pkg::*;
#(
    parameter int          H_ACTIVE  = DEF_H_ACTIVE,
    parameter int          V_ACTIVE  = DEF_V_ACTIVE,
    parameter int          OVL_W     = DEF_OVL_W,
    parameter int          OVL_H     = DEF_OVL_H,
    parameter logic [23:0] KEY_COLOR = DEF_KEY_COLOR
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        de,
    input  logic [9:0]  ovl_x,
    input  logic [9:0]  ovl_y,
    output logic [18:0] bg_addr,
    output logic        bg_rd_en,
    input  logic [23:0] bg_data,
    output logic [13:0] ovl_addr,
    output logic        ovl_rd_en,
    input  logic [23:0] ovl_data,
    output logic [23:0] pix_out,
    output logic        pix_valid,
    output logic        line_err
);

    state_e                 state_q, state_d, cur_state;
    logic [COORD_W-1:0]     x_q, x_d, cur_x;
    logic [COORD_W-1:0]     y_q, y_d, cur_y;
    logic [BG_ADDR_W-1:0]   addr_q, addr_d, cur_addr;
    logic [BG_ADDR_W-1:0]   base_q, base_d, cur_base;
    logic [9:0]             ox_q, oy_q, cur_ox, cur_oy;
    logic [OVL_ADDR_W-1:0]  ovl_addr_q, win_addr;
    logic                   in_win;
    logic                   fetch, excess;
    logic                   line_err_q, line_err_d;
    logic                   v1_q, win1_q, zero1_q;
    logic                   pix_valid_q;
    logic [23:0]            pix_out_q;

    // frame_start overrides the stored position so a coincident de is fetched as pixel 0,0.
    always_comb begin
        cur_state = frame_start ? ST_ARMED : state_q;
        cur_x     = frame_start ? '0 : x_q;
        cur_y     = frame_start ? '0 : y_q;
        cur_addr  = frame_start ? '0 : addr_q;
        cur_base  = frame_start ? '0 : base_q;
        cur_ox    = frame_start ? ovl_x : ox_q;
        cur_oy    = frame_start ? ovl_y : oy_q;
    end

    ovl_window_calc #(
        .OVL_W (OVL_W),
        .OVL_H (OVL_H)
    ) u_window (
        .x_i      (cur_x),
        .y_i      (cur_y),
        .ox_i     (cur_ox),
        .oy_i     (cur_oy),
        .in_win_o (in_win),
        .addr_o   (win_addr)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        fetch      = 1'b0;
        excess     = 1'b0;
        state_d    = cur_state;
        x_d        = cur_x;
        y_d        = cur_y;
        addr_d     = cur_addr;
        base_d     = cur_base;
        line_err_d = line_err_q;
        unique case (cur_state)
            ST_ARMED, ST_BLANK: begin
                if (de) begin
                    fetch   = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (de) begin
                    if (cur_x < COORD_W'(H_ACTIVE)) begin
                        fetch = 1'b1;
                    end else begin
                        excess     = 1'b1;
                        line_err_d = 1'b1;
                    end
                end else begin
                    if (cur_x < COORD_W'(H_ACTIVE)) line_err_d = 1'b1;
                    x_d     = '0;
                    y_d     = cur_y + COORD_W'(1);
                    base_d  = cur_base + BG_ADDR_W'(H_ACTIVE);
                    addr_d  = cur_base + BG_ADDR_W'(H_ACTIVE);
                    state_d = (cur_y + COORD_W'(1) == COORD_W'(V_ACTIVE)) ? ST_IDLE : ST_BLANK;
                end
            end
            default: ;
        endcase
        if (fetch) begin
            x_d    = cur_x + COORD_W'(1);
            addr_d = cur_addr + BG_ADDR_W'(1);
        end
    end

    assign bg_rd_en  = fetch && reset_n;
    assign bg_addr   = cur_addr;
    assign ovl_rd_en = bg_rd_en && in_win;
    assign ovl_addr  = ovl_rd_en ? win_addr : ovl_addr_q;
    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;
    assign line_err  = line_err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            ovl_addr_q  <= '0;
            line_err_q  <= 1'b0;
            v1_q        <= 1'b0;
            win1_q      <= 1'b0;
            zero1_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            ox_q        <= cur_ox;
            oy_q        <= cur_oy;
            ovl_addr_q  <= ovl_addr;
            line_err_q  <= line_err_d;
            v1_q        <= fetch || excess;
            win1_q      <= ovl_rd_en;
            zero1_q     <= excess;
            pix_valid_q <= v1_q;
            // RAM data is present in the cycle after the fetch; excess pixels output black.
            if (v1_q) begin
                if (zero1_q)
                    pix_out_q <= '0;
                else if (win1_q && ovl_data != KEY_COLOR)
                    pix_out_q <= ovl_data;
                else
                    pix_out_q <= bg_data;
            end
        end
    end

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Self-checking bench for pixel_fetch_ctrl: line/pixel-counting reference model plus directed literals.
module tb_pixel_fetch_ctrl;

    localparam int          H   = 640;
    localparam int          V   = 480;
    localparam int          OW  = 128;
    localparam int          OH  = 128;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        de = 1'b0;
    logic [9:0]  ovl_x = '0;
    logic [9:0]  ovl_y = '0;
    logic [18:0] bg_addr;
    logic        bg_rd_en;
    logic [23:0] bg_data = '0;
    logic [13:0] ovl_addr;
    logic        ovl_rd_en;
    logic [23:0] ovl_data = '0;
    logic [23:0] pix_out;
    logic        pix_valid;
    logic        line_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ovl_mode = 0;

    pixel_fetch_ctrl #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .OVL_W     (OW),
        .OVL_H     (OH),
        .KEY_COLOR (KEY)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .de          (de),
        .ovl_x       (ovl_x),
        .ovl_y       (ovl_y),
        .bg_addr     (bg_addr),
        .bg_rd_en    (bg_rd_en),
        .bg_data     (bg_data),
        .ovl_addr    (ovl_addr),
        .ovl_rd_en   (ovl_rd_en),
        .ovl_data    (ovl_data),
        .pix_out     (pix_out),
        .pix_valid   (pix_valid),
        .line_err    (line_err)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] bg_fn(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'd2654435761;
        return h[31:8];
    endfunction

    function automatic logic [23:0] ovl_fn(input int a);
        if (ovl_mode == 1) return 24'h123456;
        if (ovl_mode == 2) return KEY;
        if (a % 7 == 3) return KEY;
        return 24'(a * 40503 + 32'h000A0B0C);
    endfunction

    // Synchronous-read RAMs; unread cycles return junk so stale data cannot pass unnoticed.
    always @(posedge clock) begin
        if (bg_rd_en) bg_data <= bg_fn(int'(bg_addr));
        else          bg_data <= 24'($urandom);
        if (ovl_rd_en) ovl_data <= ovl_fn(int'(ovl_addr));
        else           ovl_data <= 24'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [23:0] val;
    } pix_t;

    pix_t pq[$];
    int   cyc      = 0;
    bit   model_on = 0;
    bit   m_run    = 0;
    bit   m_err    = 0;
    bit   m_in_line = 0;
    int   m_line   = 0;
    int   m_pix    = 0;
    int   m_ox     = 0;
    int   m_oy     = 0;
    int   m_oaddr  = 0;

    always @(negedge clock) begin
        #2;
        if (!reset_n) model_on = 1;
        if (model_on) begin
            bit exp_v;
            exp_v = (pq.size() > 0) && (pq[0].due == cyc);
            check("pix_valid", 32'(pix_valid), 32'(exp_v));
            if (exp_v) begin
                check("pix_out", 32'(pix_out), 32'(pq[0].val));
                void'(pq.pop_front());
            end
            check("line_err", 32'(line_err), 32'(m_err));
            if (!reset_n) begin
                check("bg_rd_en_rst", 32'(bg_rd_en), 32'd0);
                check("ovl_rd_en_rst", 32'(ovl_rd_en), 32'd0);
                pq.delete();
                m_run = 0; m_err = 0; m_in_line = 0;
                m_line = 0; m_pix = 0; m_oaddr = 0;
            end else begin
                bit fetch, excess, inw;
                int addr, dx, dy, oa;
                logic [23:0] ov;
                if (frame_start) begin
                    m_run = 1; m_line = 0; m_pix = 0; m_in_line = 0;
                    m_ox = int'(ovl_x); m_oy = int'(ovl_y);
                end
                fetch  = m_run && de && (m_pix < H);
                excess = m_run && de && (m_pix >= H);
                addr = m_line * H + m_pix;
                dx = m_pix - m_ox;
                dy = m_line - m_oy;
                inw = fetch && dx >= 0 && dx < OW && dy >= 0 && dy < OH;
                oa = dy * OW + dx;
                check("bg_rd_en", 32'(bg_rd_en), 32'(fetch));
                if (fetch) check("bg_addr", 32'(bg_addr), 32'(addr));
                check("ovl_rd_en", 32'(ovl_rd_en), 32'(inw));
                if (inw) m_oaddr = oa;
                check("ovl_addr", 32'(ovl_addr), 32'(m_oaddr));
                if (fetch) begin
                    ov = ovl_fn(oa);
                    pq.push_back('{due: cyc + 2, val: (inw && ov != KEY) ? ov : bg_fn(addr)});
                end
                if (excess) begin
                    pq.push_back('{due: cyc + 2, val: 24'h0});
                    m_err = 1;
                end
                if (m_run) begin
                    if (de) begin
                        m_pix++;
                        m_in_line = 1;
                    end else if (m_in_line) begin
                        if (m_pix < H) m_err = 1;
                        m_line++;
                        m_pix = 0;
                        m_in_line = 0;
                        if (m_line == V) m_run = 0;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic rst, input logic fs, input logic d);
        @(negedge clock);
        reset_n = rst;
        frame_start = fs;
        de = d;
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1);
    endtask

    task automatic start_frame(input int ox, input int oy);
        ovl_x = 10'(ox);
        ovl_y = 10'(oy);
        tick(1'b1, 1'b1, 1'b0);
        gap(2);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset, then de in IDLE must be ignored.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check("rst_bg_addr", 32'(bg_addr), 32'd0);
        check("rst_ovl_addr", 32'(ovl_addr), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_line_err", 32'(line_err), 32'd0);
        check("idle_rd_en", 32'(bg_rd_en), 32'd0);
        gap(2);

        // Overlay fully off-screen.
        start_frame(1000, 1000);
        for (int i = 0; i < H; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 0)   check("offscr_first_addr", 32'(bg_addr), 32'd0);
            if (i == 639) check("offscr_last_addr", 32'(bg_addr), 32'd639);
        end
        gap(4);

        // Constant overlay colour at x=100.
        ovl_mode = 1;
        start_frame(100, 0);
        for (int i = 0; i < H; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 100) begin
                check("win_first_en", 32'(ovl_rd_en), 32'd1);
                check("win_first_addr", 32'(ovl_addr), 32'd0);
            end
            if (i == 102) check("win_pix", 32'(pix_out), 32'h123456);
            if (i == 227) check("win_last_addr", 32'(ovl_addr), 32'd127);
            if (i == 228) check("win_after_en", 32'(ovl_rd_en), 32'd0);
        end
        gap(3);

        // Key colour everywhere shows the background.
        ovl_mode = 2;
        start_frame(100, 0);
        for (int i = 0; i < H; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 102) check("key_pix", 32'(pix_out), 32'(bg_fn(100)));
        end
        gap(3);

        // Window clipped at the right edge, no wrap into the next line.
        ovl_mode = 0;
        start_frame(600, 0);
        for (int i = 0; i < H; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 599) check("clip_before_en", 32'(ovl_rd_en), 32'd0);
            if (i == 639) check("clip_last_addr", 32'(ovl_addr), 32'd39);
        end
        gap(2);
        for (int i = 0; i < H; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 0)   check("clip_nowrap_en", 32'(ovl_rd_en), 32'd0);
            if (i == 600) check("clip_l1_addr", 32'(ovl_addr), 32'd128);
        end
        gap(2);
        check("no_err_yet", 32'(line_err), 32'd0);

        // Overlong line.
        start_frame(1000, 1000);
        for (int i = 0; i <= H; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == H) check("excess_no_fetch", 32'(bg_rd_en), 32'd0);
        end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("excess_valid", 32'(pix_valid), 32'd1);
        check("excess_black", 32'(pix_out), 32'd0);
        check("excess_err", 32'(line_err), 32'd1);
        gap(2);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 0) check("after_long_addr", 32'(bg_addr), 32'd640);
        end
        gap(2);

        // Short line.
        tick(1'b0, 1'b0, 1'b0);
        start_frame(1000, 1000);
        line(10);
        gap(2);
        check("short_err", 32'(line_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 0) check("after_short_addr", 32'(bg_addr), 32'd640);
        end
        gap(2);

        // Reset mid-line at x=300.
        tick(1'b0, 1'b0, 1'b0);
        ovl_mode = 0;
        start_frame(100, 0);
        line(300);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check("mrst_valid", 32'(pix_valid), 32'd0);
            check("mrst_rd_en", 32'(bg_rd_en | ovl_rd_en), 32'd0);
            check("mrst_addr", 32'(bg_addr | 19'(ovl_addr)), 32'd0);
            check("mrst_pix", 32'(pix_out), 32'd0);
            check("mrst_err", 32'(line_err), 32'd0);
        end
        gap(2);

        // frame_start coincident with de, mid-line.
        start_frame(1000, 1000);
        line(50);
        ovl_x = 10'd20;
        ovl_y = 10'd0;
        tick(1'b1, 1'b1, 1'b1);
        check("fs_de_en", 32'(bg_rd_en), 32'd1);
        check("fs_de_addr", 32'(bg_addr), 32'd0);
        line(H - 1);
        gap(3);

        // Randomized frames.
        for (int f = 0; f < 4; f++) begin
            ovl_mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            start_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 8)));
            gap(int'($urandom_range(0, 3)));
            for (int l = 0; l < 10; l++) begin
                int len;
                len = H;
                if ($urandom_range(0, 7) == 0) len = H - 1 + int'($urandom_range(0, 2));
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 999) == 0) begin
                        ovl_x = 10'($urandom_range(0, 1023));
                        ovl_y = 10'($urandom_range(0, 4));
                        tick(1'b1, 1'b1, 1'b1);
                    end else begin
                        tick(1'b1, 1'b0, 1'b1);
                    end
                end
                gap(int'($urandom_range(1, 4)));
            end
        end

        // Whole frame of one-pixel lines, then de is ignored.
        tick(1'b0, 1'b0, 1'b0);
        start_frame(0, 0);
        for (int l = 0; l < V; l++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (l == V - 1) check("last_line_addr", 32'(bg_addr), 32'd306560);
            tick(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (i == 5) check("post_frame_rd_en", 32'(bg_rd_en), 32'd0);
        end
        gap(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_fetch_ctrl.md
PIXEL_FETCH_CTRL -- requirements
Module: pixel_fetch_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter OVL_W, default 128: overlay width; SHALL be a power of two.
REQ-004 SHALL have parameter OVL_H, default 128: overlay height.
REQ-005 SHALL have parameter KEY_COLOR, default 24'hFF00FF: transparent overlay colour.
REQ-006 Ports, in order: clock in 1, single clock, all logic on its rising edge; reset_n in 1, synchronous active-low reset; frame_start in 1, one-cycle pulse at the start of a frame; de in 1, active-video pixel request; ovl_x in 10, overlay left column; ovl_y in 10, overlay top row; bg_addr out 19, background RAM read address; bg_rd_en out 1; bg_data in 24, returned one cycle after bg_rd_en; ovl_addr out 14, overlay RAM read address; ovl_rd_en out 1; ovl_data in 24, returned one cycle after ovl_rd_en; pix_out out 24, composited RGB; pix_valid out 1; line_err out 1, sticky timing-error flag.

Function
REQ-007 FSM states SHALL be IDLE, ARMED, ACTIVE, BLANK.
REQ-008 In any state, frame_start SHALL enter ARMED, zero x/y/bg_addr, and latch ovl_x/ovl_y for the whole frame.
REQ-009 ARMED to ACTIVE SHALL occur on the first de=1 cycle; that cycle is pixel x=0.
REQ-010 In ACTIVE, each de=1 cycle SHALL issue one fetch: bg_rd_en=1, bg_addr=y*H_ACTIVE+x, using a running counter with no multiplier; x then increments.
REQ-011 de falling in ACTIVE SHALL enter BLANK and increment y; if y reaches V_ACTIVE, the FSM SHALL enter IDLE instead.
REQ-012 BLANK to ACTIVE SHALL occur on de=1, with x=0.
REQ-013 In IDLE, de SHALL be ignored: no rd_en, no pix_valid.
REQ-014 A pixel SHALL be inside the window when x-ox is in [0,OVL_W) and y-oy is in [0,OVL_H), where ox/oy are the latched values.
REQ-015 Window comparisons SHALL use 11-bit unsigned differences, so there is no wrap-around false hit.
REQ-016 Window parts off-screen SHALL simply not be fetched.
REQ-017 Inside the window, ovl_rd_en SHALL be 1 in the same cycle as bg_rd_en, with ovl_addr=((y-oy)<<log2(OVL_W))+(x-ox).
REQ-018 Outside the window, ovl_rd_en SHALL be 0 and ovl_addr SHALL hold its value.
REQ-019 Latency SHALL be fixed: pix_valid=1 exactly two cycles after each fetch cycle.
REQ-020 pix_out SHALL be registered.
REQ-021 pix_out SHALL be ovl_data when the fetch was in-window and ovl_data != KEY_COLOR; otherwise it SHALL be bg_data.
REQ-022 The in-window flag SHALL be pipelined alongside the read latency.
REQ-023 de=1 for more than H_ACTIVE cycles on a line SHALL set line_err.
REQ-024 Excess de cycles SHALL issue no fetch and SHALL output pix_out=0 with pix_valid=1, preserving latency.
REQ-025 When the de=0 that ends the line arrives, x SHALL reset.
REQ-026 de falling before H_ACTIVE pixels SHALL set line_err; the line still ends and the next line starts at x=0.
REQ-027 line_err SHALL clear only on reset.
REQ-028 frame_start asserted together with de=1 SHALL give frame_start priority; that de cycle becomes x=0,y=0 and is fetched (ARMED is passed through in the same cycle).
REQ-029 pix_valid/pix_out for fetches already in the pipeline when frame_start arrives SHALL still complete.

Reset
REQ-030 While reset_n=0 at a clock edge, the FSM SHALL enter IDLE.
REQ-031 Reset SHALL clear x, y, bg_addr, ovl_addr, latched ox/oy, both rd_en outputs, the pipeline valid bits, pix_out (to 24'h000000), pix_valid and line_err.
REQ-032 Reset mid-line SHALL discard in-flight pixels: no pix_valid on the following cycles.
REQ-033 After reset, the block SHALL wait for frame_start.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the default geometry constants and KEY_COLOR.
REQ-035 One sub-module, ovl_window_calc, SHALL be used: combinational in-window test plus overlay address from x, y, ox, oy.

Verification
REQ-036 Reset, frame_start, then 640 de cycles with ovl_x=ovl_y=1000 (off-screen) SHALL give bg_addr 0..639, ovl_rd_en never 1, 640 pix_valid pulses each 2 cycles after de, and pix_out equal to bg_data.
REQ-037 ovl_x=100, ovl_y=0, line 0 SHALL give ovl_rd_en=1 for x=100..227 and ovl_addr=0..127.
REQ-038 With ovl_data=24'h123456, pix_out SHALL be 24'h123456 for x=100..227.
REQ-039 ovl_data=24'hFF00FF in the window SHALL give pix_out equal to bg_data.
REQ-040 ovl_x=600 SHALL give window fetches for x=600..639 only, with the last ovl_addr=39 on line 0, and no wrap-around to x=0.
REQ-041 A 641-cycle de line SHALL set line_err; the last pix_out SHALL be 0 with pix_valid=1, and the next line's bg_addr SHALL start at 640.
REQ-042 reset_n=0 at x=300 SHALL produce no pix_valid on the following cycles, all outputs zero, and IDLE until the next frame_start.
REQ-043 frame_start coincident with de SHALL fetch bg_addr=0 in that cycle.
REQ-044 After 480 lines, further de SHALL be ignored.
